// File: rtl/sin_cos_arb_pkg.sv
// Shared types and helpers for the sin_cos lookup arbiter.
// Holds phase/trig types, the request tag bundle and the id-width helper.
package sin_cos_arb_pkg;

    localparam int DEF_PHASE_W = 10;
    localparam int DEF_VAL_W   = 18;
    localparam int MAX_ID_W    = 3;

    typedef logic [DEF_PHASE_W-1:0]      phase_t;
    typedef logic signed [DEF_VAL_W-1:0] trig_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Ports: req, ptr in; one-hot gnt, winner index and any out.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    int idx;

    // Scan from ptr upward, wrapping at N; first asserted request wins.
    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                winner   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sin_cos_arbiter.sv
// Shares one sin_cos table between N_REQ requesters with round-robin grants.
// Ports: clk, reset, req/phase in; gnt, tbl_phase, rsp_valid/rsp_id/sin_val/cos_val, busy out; tbl_sin/tbl_cos in.
module sin_cos_arbiter
    import sin_cos_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int PHASE_W = 10,
    parameter int VAL_W   = 18,
    parameter int TBL_LAT = 1,
    localparam int ID_W   = id_w(N_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req,
    input  logic [N_REQ-1:0][PHASE_W-1:0]    phase,
    output logic [N_REQ-1:0]                 gnt,
    output logic [PHASE_W-1:0]               tbl_phase,
    input  logic signed [VAL_W-1:0]          tbl_sin,
    input  logic signed [VAL_W-1:0]          tbl_cos,
    output logic                             rsp_valid,
    output logic [ID_W-1:0]                  rsp_id,
    output logic signed [VAL_W-1:0]          sin_val,
    output logic signed [VAL_W-1:0]          cos_val,
    output logic                             busy
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic [N_REQ-1:0] req_live;
    logic             any;
    logic             pending;
    tag_t             tags [TBL_LAT+1];

    // Masking requests during reset forces gnt low without a separate mux.
    assign req_live = reset ? '0 : req;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req_live),
        .ptr    (ptr),
        .gnt    (gnt),
        .winner (winner),
        .any    (any)
    );

    // Valid bits that will still occupy the tag pipe next cycle; the last
    // stage drains into the output register so it is excluded.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < TBL_LAT; i++) begin
            pending = pending | tags[i].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            tbl_phase <= '0;
            for (int i = 0; i <= TBL_LAT; i++) begin
                tags[i] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            sin_val   <= '0;
            cos_val   <= '0;
            busy      <= 1'b0;
        end else begin
            if (any) begin
                ptr       <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
                tbl_phase <= phase[winner];
            end
            tags[0] <= '{valid: any, id: MAX_ID_W'(winner)};
            for (int i = 1; i <= TBL_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
            rsp_valid <= tags[TBL_LAT].valid;
            if (tags[TBL_LAT].valid) begin
                sin_val <= tbl_sin;
                cos_val <= tbl_cos;
                rsp_id  <= tags[TBL_LAT].id[ID_W-1:0];
            end
            // Registered image of the tag pipe as it will be next cycle.
            busy <= any | pending;
        end
    end

endmodule

// File: tb/tb_sin_cos_arbiter.sv
// Self-checking bench for sin_cos_arbiter with a scoreboard of expected responses.
// Two instances: default (4 req, latency 1) and 3 req with latency 3.
module tb_sin_cos_arbiter;
    import sin_cos_arb_pkg::*;

    typedef struct {
        int     id;
        phase_t ph;
        int     due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    logic [3:0]       req0;
    logic [3:0][9:0]  ph0;
    logic [3:0]       gnt0;
    logic [9:0]       tp0;
    trig_t            ts0, tc0, sv0, cv0;
    logic             rv0, busy0;
    logic [1:0]       rid0;

    logic [2:0]       req1;
    logic [2:0][9:0]  ph1;
    logic [2:0]       gnt1;
    logic [9:0]       tp1;
    trig_t            ts1, tc1, sv1, cv1;
    logic             rv1, busy1;
    logic [1:0]       rid1;

    phase_t d0;
    phase_t d1 [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic trig_t fsin(input phase_t p);
        return trig_t'({p[7:0] ^ 8'hA5, p});
    endfunction

    function automatic trig_t fcos(input phase_t p);
        return ~fsin(p);
    endfunction

    // Table model: fixed-latency pipelines from tbl_phase to sin/cos.
    always @(posedge clk) begin
        d0    <= tp0;
        d1[0] <= tp1;
        d1[1] <= d1[0];
        d1[2] <= d1[1];
    end

    assign ts0 = fsin(d0);
    assign tc0 = fcos(d0);
    assign ts1 = fsin(d1[2]);
    assign tc1 = fcos(d1[2]);

    sin_cos_arbiter #(
        .N_REQ(4), .PHASE_W(10), .VAL_W(18), .TBL_LAT(1)
    ) dut0 (
        .clk(clk), .reset(reset), .req(req0), .phase(ph0), .gnt(gnt0),
        .tbl_phase(tp0), .tbl_sin(ts0), .tbl_cos(tc0), .rsp_valid(rv0),
        .rsp_id(rid0), .sin_val(sv0), .cos_val(cv0), .busy(busy0)
    );

    sin_cos_arbiter #(
        .N_REQ(3), .PHASE_W(10), .VAL_W(18), .TBL_LAT(3)
    ) dut1 (
        .clk(clk), .reset(reset), .req(req1), .phase(ph1), .gnt(gnt1),
        .tbl_phase(tp1), .tbl_sin(ts1), .tbl_cos(tc1), .rsp_valid(rv1),
        .rsp_id(rid1), .sin_val(sv1), .cos_val(cv1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on dut0; expects to be entered just after posedge.
    task automatic step0(input logic [3:0] r, input logic [3:0] eg,
                         input bit push);
        req0 = r;
        @(negedge clk);
        chk("gnt0", 32'(gnt0), 32'(eg));
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                if (eg[k]) sb0.push_back('{id: k, ph: ph0[k], due: cyc + 3});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic [2:0] r, input logic [2:0] eg,
                         input bit push);
        req1 = r;
        @(negedge clk);
        chk("gnt1", 32'(gnt1), 32'(eg));
        if (push) begin
            for (int k = 0; k < 3; k++) begin
                if (eg[k]) sb1.push_back('{id: k, ph: ph1[k], due: cyc + 5});
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rv0) begin
            if (sb0.size() == 0) begin
                chk("rsp0_unexpected", 32'(rid0), 32'hFFFF_FFFF);
            end else begin
                e = sb0.pop_front();
                chk("rsp0_id", 32'(rid0), 32'(e.id));
                chk("rsp0_sin", 32'(sv0), 32'(fsin(e.ph)));
                chk("rsp0_cos", 32'(cv0), 32'(fcos(e.ph)));
                chk("rsp0_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sb0.size() != 0 && sb0[0].due <= cyc) begin
            e = sb0.pop_front();
            chk("rsp0_missing", 32'(rv0), 32'd1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rv1) begin
            if (sb1.size() == 0) begin
                chk("rsp1_unexpected", 32'(rid1), 32'hFFFF_FFFF);
            end else begin
                e = sb1.pop_front();
                chk("rsp1_id", 32'(rid1), 32'(e.id));
                chk("rsp1_sin", 32'(sv1), 32'(fsin(e.ph)));
                chk("rsp1_cos", 32'(cv1), 32'(fcos(e.ph)));
                chk("rsp1_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sb1.size() != 0 && sb1[0].due <= cyc) begin
            e = sb1.pop_front();
            chk("rsp1_missing", 32'(rv1), 32'd1);
        end
    end

    initial begin
        reset = 1'b1;
        req0  = '0;
        req1  = '0;
        ph0   = '0;
        ph1   = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state, with requests held high to prove gnt is forced low.
        req0 = 4'hF;
        req1 = 3'h7;
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_tbl_phase", 32'(tp0), 32'd0);
        chk("rst_rsp_valid", 32'(rv0), 32'd0);
        chk("rst_rsp_id", 32'(rid0), 32'd0);
        chk("rst_sin", 32'(sv0), 32'd0);
        chk("rst_cos", 32'(cv0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        req0  = '0;
        req1  = '0;

        // Single request on index 2.
        ph0[2] = 10'd256;
        step0(4'b0100, 4'b0100, 1'b1);
        req0 = '0;
        @(negedge clk);
        chk("single_tbl_phase", 32'(tp0), 32'd256);
        chk("single_busy", 32'(busy0), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step0(4'b0000, 4'b0000, 1'b0);
        chk("idle_busy", 32'(busy0), 32'd0);

        // All four requesting from a fresh pointer.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ph0 = {10'd768, 10'd512, 10'd256, 10'd0};
        for (int i = 0; i < 5; i++) step0(4'hF, 4'(1 << (i % 4)), 1'b1);
        for (int i = 0; i < 4; i++) step0(4'b0000, 4'b0000, 1'b0);

        // Fairness: ptr=1, req[3] continuous, req[0] joins later.
        ph0[0] = 10'h3FF;
        step0(4'b1000, 4'b1000, 1'b1);
        step0(4'b1000, 4'b1000, 1'b1);
        step0(4'b1001, 4'b0001, 1'b1);
        step0(4'b1000, 4'b1000, 1'b1);

        // Withdrawal: req[1] pulses while req[0] holds at ptr=0.
        ph0[0] = 10'h0AA;
        ph0[1] = 10'h155;
        step0(4'b0011, 4'b0001, 1'b1);
        step0(4'b0001, 4'b0001, 1'b1);
        #2;
        chk("wd_tbl_phase", 32'(tp0), 32'h0AA);
        // ptr=1 with req[1] absent: next asserted index wins.
        step0(4'b0100, 4'b0100, 1'b1);
        for (int i = 0; i < 3; i++) step0(4'b0000, 4'b0000, 1'b0);

        // Reset while two grants are in flight.
        step0(4'b0001, 4'b0001, 1'b0);
        step0(4'b0010, 4'b0010, 1'b0);
        reset = 1'b1;
        req0  = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("flush_rsp_valid", 32'(rv0), 32'd0);
            chk("flush_busy", 32'(busy0), 32'd0);
            @(posedge clk); #1;
        end
        ph0[0] = 10'h123;
        step0(4'b0011, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) step0(4'b0000, 4'b0000, 1'b0);

        // Three requesters, latency 3: pointer wraps 2 -> 0.
        ph1 = {10'h300, 10'h200, 10'h100};
        for (int i = 0; i < 4; i++) step1(3'h7, 3'(1 << (i % 3)), 1'b1);
        for (int i = 0; i < 6; i++) step1(3'b000, 3'b000, 1'b0);

        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
